// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
// Imported by rst_seq.
package rst_seq_pkg;

   typedef enum logic [2:0] {
      ST_WAIT_LOCK,
      ST_STABLE,
      ST_RELEASE,
      ST_RUN,
      ST_SOFT_HOLD
   } state_e;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

   function automatic int cnt_width(input int lw, input int sg, input int sh);
      return $clog2(max3(lw, sg, sh)) + 1;
   endfunction

endpackage

// File: rtl/lock_sync.sv
// Generic two-flop level synchroniser.
// Clears to 0 asynchronously.
module lock_sync (
   input  logic clk_in,
   input  logic rst_n_in,
   input  logic d_in,
   output logic q_out
);

   logic meta_q;

   // two-stage capture of the asynchronous level
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         meta_q <= 1'b0;
         q_out  <= 1'b0;
      end else begin
         meta_q <= d_in;
         q_out  <= meta_q;
      end
   end

endmodule

// File: rtl/rst_seq.sv
// Power-on / recovery reset sequencer.
// Releases reset domains in order after PLL lock.
module rst_seq
   import rst_seq_pkg::*;
#(
   parameter int N_STAGES  = 3,
   parameter int LOCK_WAIT = 1024,
   parameter int STAGE_GAP = 16,
   parameter int SOFT_HOLD = 8
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   input  logic                pll_locked_in,
   input  logic                soft_rst_in,
   output logic [N_STAGES-1:0] rst_n_out,
   output logic                done_out
);

   localparam int CW = cnt_width(LOCK_WAIT, STAGE_GAP, SOFT_HOLD);
   localparam int IW = $clog2(N_STAGES) + 1;

   state_e              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [N_STAGES-1:0] rst_q, rst_d;
   logic                done_q, done_d;
   logic                lock_s;

   lock_sync u_lock_sync (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .d_in     (pll_locked_in),
      .q_out    (lock_s)
   );

   // state, counters and registered outputs
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= ST_WAIT_LOCK;
         cnt_q   <= '0;
         idx_q   <= '0;
         rst_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rst_q   <= rst_d;
         done_q  <= done_d;
      end
   end

   // next-state and next-output decode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      rst_d   = rst_q;
      done_d  = done_q;
      if (state_q != ST_WAIT_LOCK && !lock_s) begin
         state_d = ST_WAIT_LOCK;
         cnt_d   = '0;
         idx_d   = '0;
         rst_d   = '0;
         done_d  = 1'b0;
      end else begin
         unique case (state_q)
            ST_WAIT_LOCK: begin
               rst_d  = '0;
               done_d = 1'b0;
               if (lock_s) begin
                  state_d = ST_STABLE;
                  cnt_d   = '0;
               end
            end
            ST_STABLE: begin
               if (cnt_q == CW'(LOCK_WAIT - 1)) begin
                  rst_d    = '0;
                  rst_d[0] = 1'b1;
                  idx_d    = IW'(1);
                  cnt_d    = '0;
                  if (N_STAGES == 1) begin
                     state_d = ST_RUN;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_RELEASE;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            ST_RELEASE: begin
               if (cnt_q == CW'(STAGE_GAP - 1)) begin
                  for (int i = 0; i < N_STAGES; i++) begin
                     if (idx_q == IW'(i)) rst_d[i] = 1'b1;
                  end
                  idx_d = idx_q + IW'(1);
                  cnt_d = '0;
                  if (idx_q == IW'(N_STAGES - 1)) begin
                     state_d = ST_RUN;
                     done_d  = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            ST_RUN: begin
               if (soft_rst_in) begin
                  state_d = ST_SOFT_HOLD;
                  rst_d   = '0;
                  done_d  = 1'b0;
                  cnt_d   = '0;
               end
            end
            ST_SOFT_HOLD: begin
               if (cnt_q == CW'(SOFT_HOLD - 1)) begin
                  if (!soft_rst_in) begin
                     rst_d    = '0;
                     rst_d[0] = 1'b1;
                     idx_d    = IW'(1);
                     cnt_d    = '0;
                     if (N_STAGES == 1) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                     end else begin
                        state_d = ST_RELEASE;
                     end
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
               idx_d   = '0;
               rst_d   = '0;
               done_d  = 1'b0;
            end
         endcase
      end
   end

   assign rst_n_out = rst_q;
   assign done_out  = done_q;

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq.
// Reference model works in elapsed lock-time arithmetic.
module tb_rst_seq;

   localparam int N  = 3;
   localparam int LW = 8;
   localparam int SG = 4;
   localparam int SH = 4;

   logic         clk_in = 1'b0;
   logic         rst_n_in = 1'b0;
   logic         pll_locked_in = 1'b0;
   logic         soft_rst_in = 1'b0;
   logic [N-1:0] rst_n_out;
   logic         done_out;

   rst_seq #(
      .N_STAGES  (N),
      .LOCK_WAIT (LW),
      .STAGE_GAP (SG),
      .SOFT_HOLD (SH)
   ) dut (
      .clk_in        (clk_in),
      .rst_n_in      (rst_n_in),
      .pll_locked_in (pll_locked_in),
      .soft_rst_in   (soft_rst_in),
      .rst_n_out     (rst_n_out),
      .done_out      (done_out)
   );

   always #5 clk_in = ~clk_in;

   int total = 0;
   int bad   = 0;
   int ncyc  = 0;

   // expected {done, rst_n_out} per cycle
   logic [N:0] exp_q[$];

   // model: pin history, lock streak, release origin, soft hold
   bit p1, p2;
   int streak;
   int t0;
   bit soft_mode;
   int hold_at;
   int cnt;

   function automatic int min2(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic model_clear();
      p1 = 0;
      p2 = 0;
      streak = 0;
      t0 = LW + 1;
      soft_mode = 0;
      hold_at = 0;
      cnt = 0;
   endtask

   task automatic model_edge();
      bit ls;
      int prev;
      if (!rst_n_in) begin
         model_clear();
         return;
      end
      ls = p2;
      p2 = p1;
      p1 = pll_locked_in;
      prev = cnt;
      if (!ls) begin
         streak = 0;
         t0 = LW + 1;
         soft_mode = 0;
         cnt = 0;
         return;
      end
      streak++;
      if (soft_mode) begin
         if (!soft_rst_in && (streak - hold_at) >= SH) begin
            soft_mode = 0;
            t0 = streak;
         end
      end else if (prev == N && soft_rst_in) begin
         soft_mode = 1;
         hold_at = streak;
      end
      if (!soft_mode && streak >= t0)
         cnt = min2(N, (streak - t0) / SG + 1);
      else
         cnt = 0;
   endtask

   function automatic logic [N:0] model_out();
      logic [N-1:0] r;
      r = N'((1 << cnt) - 1);
      return {(cnt == N), r};
   endfunction

   // one cycle: account for the edge, apply next inputs, push expectation
   task automatic cyc(input bit r, input bit l, input bit s);
      @(posedge clk_in);
      #1;
      model_edge();
      rst_n_in = r;
      pll_locked_in = l;
      soft_rst_in = s;
      if (!r) model_clear();
      exp_q.push_back(model_out());
   endtask

   task automatic run(input int n, input bit r, input bit l, input bit s);
      for (int i = 0; i < n; i++) cyc(r, l, s);
   endtask

   // monitor: compare DUT against the oldest expectation
   always @(negedge clk_in) begin
      logic [N:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         ncyc++;
         total++;
         if (rst_n_out !== e[N-1:0]) begin
            bad++;
            $display("FAIL rst_n_out cyc=%0d got=%b want=%b",
                     ncyc, rst_n_out, e[N-1:0]);
         end
         total++;
         if (done_out !== e[N]) begin
            bad++;
            $display("FAIL done_out cyc=%0d got=%b want=%b",
                     ncyc, done_out, e[N]);
         end
      end
   end

   initial begin
      model_clear();
      // 1: reset with lock high, then full power-on sequence
      run(5, 0, 1, 0);
      run(30, 1, 1, 0);
      // 3: single-cycle soft pulse in RUN
      cyc(1, 1, 1);
      run(25, 1, 1, 0);
      // 4: soft held 10 cycles
      run(10, 1, 1, 1);
      run(25, 1, 1, 0);
      // 2: lock glitch during STABLE
      run(3, 0, 1, 0);
      run(8, 1, 1, 0);
      cyc(1, 0, 0);
      run(30, 1, 1, 0);
      // 5: lock loss in RELEASE at 3'b011
      run(3, 0, 1, 0);
      run(16, 1, 1, 0);
      run(5, 1, 0, 0);
      run(30, 1, 1, 0);
      // 6: async reset mid-RELEASE, then restart
      run(3, 0, 1, 0);
      run(14, 1, 1, 0);
      run(2, 0, 1, 0);
      run(30, 1, 1, 0);
      // soft request outside RUN is ignored
      run(3, 0, 1, 0);
      run(12, 1, 1, 1);
      run(20, 1, 1, 0);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bit r, l, s;
         r = ($urandom % 300) != 0;
         l = ($urandom % 80) != 0;
         s = ($urandom % 12) == 0;
         cyc(r, l, s);
      end
      @(negedge clk_in);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
